// File: rtl/systolic_feeder.sv
// Operand staging and diagonal-skew feeder for the systolic PE array.
// Holds one A and one B matrix and streams them skewed into the array's left and top edges.
module systolic_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ld_valid_i,
    input  logic                 ld_sel_i,
    input  logic [((BUS_WIDTH/DATA_WIDTH) > 1 ? $clog2(BUS_WIDTH/DATA_WIDTH) : 1)-1:0] ld_row_i,
    input  logic [BUS_WIDTH-1:0] ld_data_i,
    output logic                 ld_ready_o,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic                 release_i,
    output logic [BUS_WIDTH-1:0] left_o,
    output logic [BUS_WIDTH-1:0] up_o,
    output logic                 start_bit_o,
    output logic                 mode_bit_o,
    output logic                 done_o,
    output logic                 busy_o
);

    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int ROW_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int STEPS   = 3 * MAX_DIM - 2;
    localparam int T_W     = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [T_W-1:0] T_LAST = T_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD
    } state_t;

    typedef logic [DATA_WIDTH-1:0] elem_t;

    state_t         state_q, state_d;
    logic [T_W-1:0] t_q, t_d;
    elem_t          a_q [MAX_DIM][MAX_DIM];
    elem_t          a_d [MAX_DIM][MAX_DIM];
    elem_t          b_q [MAX_DIM][MAX_DIM];
    elem_t          b_d [MAX_DIM][MAX_DIM];
    logic [BUS_WIDTH-1:0] left_q, left_d;
    logic [BUS_WIDTH-1:0] up_q, up_d;
    logic           start_bit_q, start_bit_d;
    logic           mode_bit_q, mode_bit_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           ld_ready_q, ld_ready_d;
    logic           lanes_en;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can infer a latch.
        state_d     = state_q;
        t_d         = t_q;
        a_d         = a_q;
        b_d         = b_q;
        left_d      = '0;
        up_d        = '0;
        start_bit_d = start_bit_q;
        mode_bit_d  = mode_bit_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        ld_ready_d  = ld_ready_q;
        lanes_en    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ld_valid_i) begin
                    // A load wins over a simultaneous start; start must be reasserted.
                    for (int i = 0; i < MAX_DIM; i++) begin
                        if (ld_row_i == ROW_W'(i)) begin
                            for (int j = 0; j < MAX_DIM; j++) begin
                                if (ld_sel_i) b_d[i][j] = ld_data_i[j*DATA_WIDTH +: DATA_WIDTH];
                                else          a_d[i][j] = ld_data_i[j*DATA_WIDTH +: DATA_WIDTH];
                            end
                        end
                    end
                end else if (start_i) begin
                    state_d     = S_RUN;
                    t_d         = '0;
                    start_bit_d = 1'b1;
                    mode_bit_d  = mode_i;
                    busy_d      = 1'b1;
                    ld_ready_d  = 1'b0;
                    lanes_en    = 1'b1;
                end
            end
            S_RUN: begin
                if (t_q == T_LAST) begin
                    state_d    = S_HOLD;
                    mode_bit_d = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    t_d      = t_q + T_W'(1);
                    lanes_en = 1'b1;
                end
            end
            S_HOLD: begin
                if (release_i) begin
                    state_d     = S_IDLE;
                    start_bit_d = 1'b0;
                    busy_d      = 1'b0;
                    ld_ready_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered lanes carry the step being entered, so step 0 shows right after start.
        if (lanes_en) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int k = 0; k < MAX_DIM; k++) begin
                    if (int'(t_d) == r + k) begin
                        left_d[r*DATA_WIDTH +: DATA_WIDTH] = a_q[r][k];
                        up_d[r*DATA_WIDTH +: DATA_WIDTH]   = b_q[k][r];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            // NOTE: the operand stores are cleared on reset too, so an aborted run never replays stale data.
            for (int i = 0; i < MAX_DIM; i++) begin
                for (int j = 0; j < MAX_DIM; j++) begin
                    a_q[i][j] <= '0;
                    b_q[i][j] <= '0;
                end
            end
            left_q      <= '0;
            up_q        <= '0;
            start_bit_q <= 1'b0;
            mode_bit_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ld_ready_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q     <= state_d;
            t_q         <= t_d;
            a_q         <= a_d;
            b_q         <= b_d;
            left_q      <= left_d;
            up_q        <= up_d;
            start_bit_q <= start_bit_d;
            mode_bit_q  <= mode_bit_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ld_ready_q  <= ld_ready_d;
        end
    end

    assign left_o      = left_q;
    assign up_o        = up_q;
    assign start_bit_o = start_bit_q;
    assign mode_bit_o  = mode_bit_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign ld_ready_o  = ld_ready_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: expected per-cycle outputs are queued when
// stimulus is driven and compared as the DUT produces them.
module tb_systolic_feeder;

    localparam int DW    = 32;
    localparam int BW    = 64;
    localparam int N     = BW / DW;
    localparam int STEPS = 3 * N - 2;

    typedef struct packed {
        logic [BW-1:0] left;
        logic [BW-1:0] up;
        logic          sb;
        logic          mb;
        logic          done;
        logic          busy;
        logic          rdy;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          ld_valid_i = 1'b0;
    logic          ld_sel_i = 1'b0;
    logic [0:0]    ld_row_i = '0;
    logic [BW-1:0] ld_data_i = '0;
    logic          ld_ready_o;
    logic          start_i = 1'b0;
    logic          mode_i = 1'b0;
    logic          release_i = 1'b0;
    logic [BW-1:0] left_o;
    logic [BW-1:0] up_o;
    logic          start_bit_o;
    logic          mode_bit_o;
    logic          done_o;
    logic          busy_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    exp_t got, want;
    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mbm [N][N];

    systolic_feeder #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ld_valid_i  (ld_valid_i),
        .ld_sel_i    (ld_sel_i),
        .ld_row_i    (ld_row_i),
        .ld_data_i   (ld_data_i),
        .ld_ready_o  (ld_ready_o),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .release_i   (release_i),
        .left_o      (left_o),
        .up_o        (up_o),
        .start_bit_o (start_bit_o),
        .mode_bit_o  (mode_bit_o),
        .done_o      (done_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic exp_t sample();
        exp_t s;
        s.left = left_o;
        s.up   = up_o;
        s.sb   = start_bit_o;
        s.mb   = mode_bit_o;
        s.done = done_o;
        s.busy = busy_o;
        s.rdy  = ld_ready_o;
        return s;
    endfunction

    function automatic exp_t mk(logic [BW-1:0] l, logic [BW-1:0] u, logic sb, logic mb,
                                logic dn, logic bz, logic rd);
        exp_t e;
        e.left = l; e.up = u; e.sb = sb; e.mb = mb; e.done = dn; e.busy = bz; e.rdy = rd;
        return e;
    endfunction

    function automatic exp_t idle_exp();
        return mk('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic exp_t hold_exp(logic dn);
        return mk('0, '0, 1'b1, 1'b0, dn, 1'b1, 1'b0);
    endfunction

    // Reference skew: left lane r = A[r][t-r], up lane c = B[t-c][c], zero outside the matrix.
    function automatic exp_t step_exp(int t, logic m);
        exp_t e = mk('0, '0, 1'b1, m, 1'b0, 1'b1, 1'b0);
        for (int lane = 0; lane < N; lane++) begin
            int idx = t - lane;
            if (idx >= 0 && idx < N) begin
                e.left[lane*DW +: DW] = ma[lane][idx];
                e.up[lane*DW +: DW]   = mbm[idx][lane];
            end
        end
        return e;
    endfunction

    task automatic push_run(logic m);
        for (int t = 0; t < STEPS; t++) q.push_back(step_exp(t, m));
        q.push_back(hold_exp(1'b1));
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j]  = '0;
                mbm[i][j] = '0;
            end
    endtask

    task automatic load_row(logic sel, int row, logic [DW-1:0] e0, logic [DW-1:0] e1);
        ld_valid_i = 1'b1;
        ld_sel_i   = sel;
        ld_row_i   = 1'(row);
        ld_data_i  = {e1, e0};
        @(negedge clk_i);
        ld_valid_i = 1'b0;
        if (sel) begin mbm[row][0] = e0; mbm[row][1] = e1; end
        else     begin ma[row][0]  = e0; ma[row][1]  = e1; end
    endtask

    // Start a run, compare every RUN cycle plus the done cycle, then release and check IDLE.
    task automatic run_and_release(logic m, string tag, logic use_model);
        if (use_model) push_run(m);
        start_i = 1'b1;
        mode_i  = m;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < STEPS + 1; k++) begin
            got = sample();
            want = q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got left=%h up=%h sb=%b mb=%b done=%b busy=%b rdy=%b, want left=%h up=%h sb=%b mb=%b done=%b busy=%b rdy=%b",
                         tag, k, got.left, got.up, got.sb, got.mb, got.done, got.busy, got.rdy,
                         want.left, want.up, want.sb, want.mb, want.done, want.busy, want.rdy);
            end
            @(negedge clk_i);
        end
        release_i = 1'b1;
        @(negedge clk_i);
        release_i = 1'b0;
        got = sample();
        n_checks++;
        if (got !== idle_exp()) begin
            n_fail++;
            $display("FAIL %s release: got sb=%b busy=%b rdy=%b done=%b, want sb=0 busy=0 rdy=1 done=0",
                     tag, got.sb, got.busy, got.rdy, got.done);
        end
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        start_i = 1'b1;
        clear_model();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            got = sample();
            n_checks++;
            if (got !== idle_exp()) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got busy=%b sb=%b rdy=%b left=%h up=%h, want idle zeros with rdy=1",
                         k, got.busy, got.sb, got.rdy, got.left, got.up);
            end
        end
        rst_i   = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        got = sample();
        n_checks++;
        if (got !== idle_exp()) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b sb=%b rdy=%b, want busy=0 sb=0 rdy=1",
                     got.busy, got.sb, got.rdy);
        end
    endtask

    task automatic test_basic_skew();
        load_row(1'b0, 0, 32'd1, 32'd2);
        load_row(1'b0, 1, 32'd3, 32'd4);
        load_row(1'b1, 0, 32'd5, 32'd6);
        load_row(1'b1, 1, 32'd7, 32'd8);
        // Lane vectors written {lane1, lane0}.
        q.push_back(mk({32'd0, 32'd1}, {32'd0, 32'd5}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk({32'd3, 32'd2}, {32'd6, 32'd7}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk({32'd4, 32'd0}, {32'd8, 32'd0}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk({32'd0, 32'd0}, {32'd0, 32'd0}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        q.push_back(hold_exp(1'b1));
        run_and_release(1'b0, "basic_skew", 1'b0);
    endtask

    task automatic test_mode_hold();
        push_run(1'b1);
        start_i = 1'b1;
        mode_i  = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        mode_i  = 1'b0;
        for (int k = 0; k < STEPS + 1; k++) begin
            got = sample();
            want = q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL mode_run cycle %0d: got mb=%b sb=%b done=%b left=%h, want mb=%b sb=%b done=%b left=%h",
                         k, got.mb, got.sb, got.done, got.left, want.mb, want.sb, want.done, want.left);
            end
            @(negedge clk_i);
        end
        for (int k = 0; k < 20; k++) begin
            got = sample();
            n_checks++;
            if (got !== hold_exp(1'b0)) begin
                n_fail++;
                $display("FAIL hold_persist cycle %0d: got sb=%b mb=%b done=%b busy=%b, want sb=1 mb=0 done=0 busy=1",
                         k, got.sb, got.mb, got.done, got.busy);
            end
            @(negedge clk_i);
        end
        release_i = 1'b1;
        @(negedge clk_i);
        release_i = 1'b0;
        got = sample();
        n_checks++;
        if (got !== idle_exp()) begin
            n_fail++;
            $display("FAIL hold_release: got sb=%b busy=%b rdy=%b, want sb=0 busy=0 rdy=1",
                     got.sb, got.busy, got.rdy);
        end
    endtask

    task automatic test_collision();
        // Load and start in the same IDLE cycle: load happens, start is dropped.
        ld_valid_i = 1'b1; ld_sel_i = 1'b0; ld_row_i = 1'b1; ld_data_i = {32'd8, 32'd7};
        start_i = 1'b1;
        @(negedge clk_i);
        ld_valid_i = 1'b0;
        start_i    = 1'b0;
        ma[1][0] = 32'd7; ma[1][1] = 32'd8;
        for (int k = 0; k < 2; k++) begin
            got = sample();
            n_checks++;
            if (got !== idle_exp()) begin
                n_fail++;
                $display("FAIL collision_idle %0d: got busy=%b sb=%b rdy=%b, want busy=0 sb=0 rdy=1",
                         k, got.busy, got.sb, got.rdy);
            end
            @(negedge clk_i);
        end
        // Load, start and release during RUN must all be ignored.
        push_run(1'b0);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < STEPS + 1; k++) begin
            got = sample();
            want = q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL run_ignore cycle %0d: got left=%h up=%h rdy=%b busy=%b done=%b, want left=%h up=%h rdy=%b busy=%b done=%b",
                         k, got.left, got.up, got.rdy, got.busy, got.done,
                         want.left, want.up, want.rdy, want.busy, want.done);
            end
            if (k == 1) begin
                ld_valid_i = 1'b1; ld_sel_i = 1'b0; ld_row_i = 1'b0;
                ld_data_i = {32'hDEADBEEF, 32'hCAFEF00D};
                start_i = 1'b1; release_i = 1'b1;
            end else begin
                ld_valid_i = 1'b0; start_i = 1'b0; release_i = 1'b0;
            end
            @(negedge clk_i);
        end
        // Start during HOLD has no effect.
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        got = sample();
        n_checks++;
        if (got !== hold_exp(1'b0)) begin
            n_fail++;
            $display("FAIL hold_start_ignored: got sb=%b busy=%b done=%b left=%h, want sb=1 busy=1 done=0 left=0",
                     got.sb, got.busy, got.done, got.left);
        end
        release_i = 1'b1;
        @(negedge clk_i);
        release_i = 1'b0;
        // Model untouched by the RUN-time load, so this run proves memory unchanged.
        run_and_release(1'b0, "after_run_load", 1'b1);
    endtask

    task automatic test_reset_mid_run();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        clear_model();
        got = sample();
        n_checks++;
        if (got !== idle_exp()) begin
            n_fail++;
            $display("FAIL reset_mid_run: got sb=%b mb=%b busy=%b left=%h up=%h rdy=%b, want all 0 rdy=1",
                     got.sb, got.mb, got.busy, got.left, got.up, got.rdy);
        end
        load_row(1'b0, 0, 32'd1, 32'd0);
        load_row(1'b0, 1, 32'd0, 32'd1);
        load_row(1'b1, 0, 32'hFFFFFFFF, 32'd2);
        load_row(1'b1, 1, 32'd3, 32'hFFFFFFFC);
        run_and_release(1'b0, "signed_passthru", 1'b1);
    endtask

    task automatic test_overwrite();
        load_row(1'b0, 0, 32'd1, 32'd2);
        load_row(1'b0, 0, 32'd9, 32'd9);
        run_and_release(1'b0, "overwrite", 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic_skew();
        test_mode_hold();
        test_collision();
        test_reset_mid_run();
        test_overwrite();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
